router_pkt_fifo: RTL and testbench
==================================

# router_pkt_fifo

Parametrised packet FIFO for the router's per-destination output channels. It is the successor to the fixed 16x8 output FIFO and adds:
- configurable width and depth;
- a true full flag at DEPTH entries;
- almost-full/almost-empty thresholds, an occupancy count and a valid strobe;
- a last-byte-of-packet pulse and sticky overflow/underflow flags.

It sits between the router register block (write side) and the destination read interface, one instance per output port.

## Interface
- DATA_W, 8, byte width; header length field is datain[DATA_W-1:2]
- DEPTH, 16, entries; power of two, >= 4
- AF_LEVEL, DEPTH-2, almost_full asserts when level >= AF_LEVEL
- AE_LEVEL, 2, almost_empty asserts when level <= AE_LEVEL
- clk  in  1  single clock, all logic on rising edge
- resetn  in  1  synchronous, active-low reset
- soft_reset  in  1  synchronous channel flush (time-out), active-high
- write_enb  in  1  write request
- read_enb  in  1  read request
- lfd_state  in  1  load-first-data; tags the byte written on the following cycle as header
- datain  in  DATA_W  write data
- dataout  out  DATA_W  registered read data
- dataout_valid  out  1  dataout carries a byte popped on the previous edge
- pkt_last  out  1  coincident with dataout_valid for the final (parity) byte of a packet
- full  out  1  level == DEPTH
- empty  out  1  level == 0
- almost_full  out  1  level >= AF_LEVEL
- almost_empty  out  1  level <= AE_LEVEL
- level  out  $clog2(DEPTH)+1  occupancy
- ovf_err  out  1  sticky: write_enb while full
- unf_err  out  1  sticky: read_enb while empty

## Operation
- Entry is DATA_W+1 bits: {hdr_tag, data}. hdr_tag is lfd_state registered one cycle (lfd_q); it is written with the byte whose write edge follows the lfd_state cycle.
- Write accepted at an edge iff write_enb && !full. Read accepted iff read_enb && !empty. Both flags use pre-edge state.
- Simultaneous accepted read and write: level unchanged, both pointers advance.
- When full with both requested, only the read is performed. When empty with both requested, only the write is performed; no write-through.
- Pointers are log2(DEPTH) bits and wrap naturally; level tracks occupancy separately.
- Packet counter rem (DATA_W-1 bits):
  - On an accepted read of a tagged entry: rem <= length+1 (payload plus parity).
  - On an accepted read of an untagged entry with rem != 0: rem <= rem-1.
  - pkt_last registers (untagged read && rem == 1).
  - A header with length 0 gives rem = 1; the next byte read is last.
- dataout updates only on an accepted read and holds otherwise; no tri-state.
- ovf_err and unf_err set on a rejected request and clear only on reset or soft_reset.
- resetn low: pointers, level, rem, lfd_q, dataout, dataout_valid, pkt_last, ovf_err and unf_err all go to 0. Resulting outputs: empty=1, almost_empty=1, full=0, almost_full=0.
- soft_reset high (resetn high): same clear as resetn, in the same cycle. It overrides any write or read at that edge. Storage contents are not cleared; stale entries are unreachable because the pointers are reset.

## Timing
- Write to readable: an entry written at edge N makes empty=0 after edge N; a read may be accepted at edge N+1.
- Read latency 1. Read accepted at edge N gives dataout, dataout_valid=1 and pkt_last valid after edge N. dataout_valid drops after the next edge with no accepted read.
- full, empty, almost_* decode combinationally from the level register; there are no input-to-output combinational paths.
- Back-to-back reads every cycle sustain one byte per clock, and likewise for writes.
- Reset or soft_reset mid-packet abandons the packet: rem is cleared and no pkt_last is issued.

## Structure
- Shared package router_pkg holds:
  - header field positions (HDR_LEN_LSB=2);
  - the default DATA_W and DEPTH;
  - a level-width helper function.
- Sub-module router_fifo_mem: DEPTH x (DATA_W+1) array with one write port and one synchronous read port, no reset. The top level keeps pointers, level, rem, flags and error logic.

## Test plan
- Reset, then write header 0x0C (length 3) with lfd_state pulsed the cycle before, then 3 payload bytes and a parity byte. Read 5 bytes -> dataout 0x0C, p1, p2, p3, parity; pkt_last=1 only with parity; level returns 0.
- Fill 16 writes (defaults) -> full=1 at level 16, almost_full from level 14. A 17th write -> ignored, ovf_err=1, contents intact.
- Read while empty -> unf_err=1, dataout unchanged, dataout_valid=0.
- At level 16, read_enb and write_enb together -> read only, level 15. At level 0, both together -> write only, level 1, dataout_valid=0.
- Write 12, read 12, write 10, read 10 -> pointers wrap, data in order, no spurious flags.
- soft_reset mid-packet at level 5 -> next cycle level 0, empty=1, errors cleared, rem=0. A new packet then reads correctly with its own pkt_last.

Source files
------------

// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared constants and helpers for the router packet FIFO
package router_pkg;

    // Header byte layout: length lives above the two low tag bits
    localparam int HDR_LEN_LSB = 2;

    // Default channel geometry
    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 16;

    // Occupancy counter width: must represent 0..depth inclusive
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/router_fifo_mem.sv
// rtl/router_fifo_mem.sv - FIFO storage array, one write port and one registered read port
module router_fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DATA_W:0]          wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [DATA_W:0]          rd_data
);

    logic [DATA_W:0] mem [DEPTH];

    // Write port: store {hdr_tag, data}; contents are never reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port: output register loads only on a read and holds otherwise
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/router_pkt_fifo.sv
// rtl/router_pkt_fifo.sv - per-destination packet FIFO with flags, level and packet tracking
module router_pkt_fifo
    import router_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic                            soft_reset,
    input  logic                            write_enb,
    input  logic                            read_enb,
    input  logic                            lfd_state,
    input  logic [DATA_W-1:0]               datain,
    output logic [DATA_W-1:0]               dataout,
    output logic                            dataout_valid,
    output logic                            pkt_last,
    output logic                            full,
    output logic                            empty,
    output logic                            almost_full,
    output logic                            almost_empty,
    output logic [level_width(DEPTH)-1:0]   level,
    output logic                            ovf_err,
    output logic                            unf_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = level_width(DEPTH);
    localparam int REM_W = DATA_W - 1;
    localparam int LEN_W = DATA_W - HDR_LEN_LSB;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [REM_W-1:0] rem;
    logic             lfd_q;
    logic             out_loaded;
    logic             clear;
    logic             wr_acc;
    logic             rd_acc;
    logic [DATA_W:0]  rd_entry;
    logic [LEN_W-1:0] hdr_len;

    // Flags decode from the level register only
    assign full         = (level == LVL_W'(DEPTH));
    assign empty        = (level == '0);
    assign almost_full  = (level >= LVL_W'(AF_LEVEL));
    assign almost_empty = (level <= LVL_W'(AE_LEVEL));

    // Flush and reset take priority over any request at the same edge
    assign clear  = !resetn || soft_reset;
    assign wr_acc = !clear && write_enb && !full;
    assign rd_acc = !clear && read_enb && !empty;

    router_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data ({lfd_q, datain}),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr),
        .rd_data (rd_entry)
    );

    // The storage register has no reset, so present zero until the first read after a clear
    assign dataout = out_loaded ? rd_entry[DATA_W-1:0] : '0;
    assign hdr_len = rd_entry[DATA_W-1:HDR_LEN_LSB];

    // The popped entry is only visible after its read edge, so the packet
    // counter is advanced one cycle later while that entry is on dataout;
    // rem therefore still describes the bytes before the one being presented
    assign pkt_last = dataout_valid && !rd_entry[DATA_W] && (rem == REM_W'(1));

    // Pointers and occupancy
    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Header tag delay and read-side output strobes
    always_ff @(posedge clk) begin
        if (clear) begin
            lfd_q         <= 1'b0;
            dataout_valid <= 1'b0;
            out_loaded    <= 1'b0;
        end else begin
            lfd_q         <= lfd_state;
            dataout_valid <= rd_acc;
            if (rd_acc) begin
                out_loaded <= 1'b1;
            end
        end
    end

    // Packet byte counter, driven by the entry currently on dataout
    always_ff @(posedge clk) begin
        if (clear) begin
            rem <= '0;
        end else if (dataout_valid) begin
            if (rd_entry[DATA_W]) begin
                rem <= REM_W'(hdr_len) + REM_W'(1);
            end else if (rem != '0) begin
                rem <= rem - REM_W'(1);
            end
        end
    end

    // Sticky error flags for rejected requests
    always_ff @(posedge clk) begin
        if (clear) begin
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
        end else begin
            if (write_enb && full) begin
                ovf_err <= 1'b1;
            end
            if (read_enb && empty) begin
                unf_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_router_pkt_fifo.sv
// tb/tb_router_pkt_fifo.sv - randomized and directed self-checking bench for router_pkt_fifo
module tb_router_pkt_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int LW     = 5;

    logic          clk = 1'b0;
    logic          resetn;
    logic          soft_reset;
    logic          write_enb;
    logic          read_enb;
    logic          lfd_state;
    logic [7:0]    datain;
    logic [7:0]    dataout;
    logic          dataout_valid;
    logic          pkt_last;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [LW-1:0] level;
    logic          ovf_err;
    logic          unf_err;

    int checks   = 0;
    int failures = 0;

    logic [8:0] mq[$];
    logic [7:0] m_dout;
    logic       m_valid;
    logic       m_last;
    logic       m_ovf;
    logic       m_unf;
    logic       m_lfd;
    int         m_rem;

    always #5 clk = ~clk;

    router_pkt_fifo #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .AF_LEVEL (DEPTH - 2),
        .AE_LEVEL (2)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .soft_reset    (soft_reset),
        .write_enb     (write_enb),
        .read_enb      (read_enb),
        .lfd_state     (lfd_state),
        .datain        (datain),
        .dataout       (dataout),
        .dataout_valid (dataout_valid),
        .pkt_last      (pkt_last),
        .full          (full),
        .empty         (empty),
        .almost_full   (almost_full),
        .almost_empty  (almost_empty),
        .level         (level),
        .ovf_err       (ovf_err),
        .unf_err       (unf_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference behaviour at one rising edge, using the inputs currently driven
    task automatic model_edge();
        logic [8:0] e;
        int         sz;
        sz = mq.size();
        if (!resetn || soft_reset) begin
            mq.delete();
            m_dout  = 8'h00;
            m_valid = 1'b0;
            m_last  = 1'b0;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
            m_lfd   = 1'b0;
            m_rem   = 0;
        end else begin
            if (write_enb && sz == DEPTH) m_ovf = 1'b1;
            if (read_enb && sz == 0)      m_unf = 1'b1;
            m_valid = 1'b0;
            m_last  = 1'b0;
            if (read_enb && sz != 0) begin
                e       = mq.pop_front();
                m_dout  = e[7:0];
                m_valid = 1'b1;
                if (e[8]) begin
                    m_rem = int'(e[7:2]) + 1;
                end else begin
                    m_last = (m_rem == 1);
                    if (m_rem != 0) m_rem = m_rem - 1;
                end
            end
            if (write_enb && sz != DEPTH) mq.push_back({m_lfd, datain});
            m_lfd = lfd_state;
        end
    endtask

    task automatic compare();
        int sz;
        sz = mq.size();
        chk("dataout",       32'(dataout),       32'(m_dout));
        chk("dataout_valid", 32'(dataout_valid), 32'(m_valid));
        chk("pkt_last",      32'(pkt_last),      32'(m_last));
        chk("level",         32'(level),         32'(sz));
        chk("full",          32'(full),          32'(sz == DEPTH));
        chk("empty",         32'(empty),         32'(sz == 0));
        chk("almost_full",   32'(almost_full),   32'(sz >= DEPTH - 2));
        chk("almost_empty",  32'(almost_empty),  32'(sz <= 2));
        chk("ovf_err",       32'(ovf_err),       32'(m_ovf));
        chk("unf_err",       32'(unf_err),       32'(m_unf));
    endtask

    task automatic step(input logic we, input logic re, input logic lfd,
                        input logic [7:0] d, input logic sr);
        write_enb  = we;
        read_enb   = re;
        lfd_state  = lfd;
        datain     = d;
        soft_reset = sr;
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    initial begin
        logic [7:0] pkt [5];
        pkt[0] = 8'h0C; pkt[1] = 8'hA1; pkt[2] = 8'hA2; pkt[3] = 8'hA3; pkt[4] = 8'h5E;
        m_dout = 8'h00; m_valid = 1'b0; m_last = 1'b0;
        m_ovf = 1'b0; m_unf = 1'b0; m_lfd = 1'b0; m_rem = 0;

        // Reset
        resetn = 1'b0;
        step(0, 0, 0, 8'h00, 0);
        step(0, 0, 0, 8'h00, 0);
        resetn = 1'b1;
        chk("rst_empty",        32'(empty),        32'd1);
        chk("rst_almost_empty", 32'(almost_empty), 32'd1);
        chk("rst_level",        32'(level),        32'd0);
        chk("rst_full",         32'(full),         32'd0);

        // One packet: header length 3, three payload bytes, parity
        step(0, 0, 1, 8'h00, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, pkt[i], 0);
        chk("pkt_level5", 32'(level), 32'd5);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0, 8'h00, 0);
            chk("pkt_byte", 32'(dataout), 32'(pkt[i]));
            chk("pkt_last_lit", 32'(pkt_last), 32'(i == 4));
        end
        chk("pkt_level0", 32'(level), 32'd0);

        // Fill to full, overflow attempt, simultaneous read+write at full
        for (int i = 0; i < 16; i++) begin
            step(1, 0, 0, 8'(8'h10 + i), 0);
            if (i == 12) chk("af_at13", 32'(almost_full), 32'd0);
            if (i == 13) chk("af_at14", 32'(almost_full), 32'd1);
        end
        chk("full16", 32'(full), 32'd1);
        step(1, 0, 0, 8'hEE, 0);
        chk("ovf_lit", 32'(ovf_err), 32'd1);
        chk("ovf_level", 32'(level), 32'd16);
        step(1, 1, 0, 8'hEF, 0);
        chk("both_full_level", 32'(level), 32'd15);
        chk("both_full_data", 32'(dataout), 32'h10);
        for (int i = 1; i < 16; i++) begin
            step(0, 1, 0, 8'h00, 0);
            chk("drain_data", 32'(dataout), 32'(8'h10 + i));
        end

        // Underflow and simultaneous request while empty
        step(0, 1, 0, 8'h00, 0);
        chk("unf_lit", 32'(unf_err), 32'd1);
        chk("unf_valid", 32'(dataout_valid), 32'd0);
        chk("unf_hold", 32'(dataout), 32'h1F);
        step(1, 1, 0, 8'h77, 0);
        chk("both_empty_level", 32'(level), 32'd1);
        chk("both_empty_valid", 32'(dataout_valid), 32'd0);
        step(0, 1, 0, 8'h00, 0);
        chk("both_empty_data", 32'(dataout), 32'h77);

        // Pointer wrap
        for (int i = 0; i < 12; i++) step(1, 0, 0, 8'($urandom), 0);
        for (int i = 0; i < 12; i++) step(0, 1, 0, 8'h00, 0);
        for (int i = 0; i < 10; i++) step(1, 0, 0, 8'($urandom), 0);
        for (int i = 0; i < 10; i++) step(0, 1, 0, 8'h00, 0);

        // Soft reset mid-packet at level 5
        step(0, 0, 1, 8'h00, 0);
        step(1, 0, 0, 8'h20, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 8'(8'h30 + i), 0);
        step(0, 1, 0, 8'h00, 0);
        chk("sr_pre_level", 32'(level), 32'd5);
        step(1, 1, 0, 8'h99, 1);
        chk("sr_level", 32'(level), 32'd0);
        chk("sr_empty", 32'(empty), 32'd1);
        chk("sr_unf", 32'(unf_err), 32'd0);
        chk("sr_ovf", 32'(ovf_err), 32'd0);
        step(0, 0, 1, 8'h00, 0);
        step(1, 0, 0, 8'h00, 0);
        step(1, 0, 0, 8'h6B, 0);
        step(0, 1, 0, 8'h00, 0);
        chk("sr_hdr_last", 32'(pkt_last), 32'd0);
        step(0, 1, 0, 8'h00, 0);
        chk("sr_par_data", 32'(dataout), 32'h6B);
        chk("sr_par_last", 32'(pkt_last), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            resetn = ($urandom_range(0, 999) >= 3);
            step(logic'($urandom_range(0, 99) < 55),
                 logic'($urandom_range(0, 99) < 50),
                 logic'($urandom_range(0, 99) < 10),
                 8'($urandom),
                 logic'($urandom_range(0, 999) < 5));
        end
        resetn = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
